// File: rtl/out_rd_scheduler.sv
// Per-output-port read scheduler: arbitrates NUM_QUEUE descriptor queues, then
// sequences one header beat and cur_len payload FIFO reads under back-pressure.
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 16
`endif

module out_rd_scheduler #(
  parameter int NUM_QUEUE = 8,
  parameter int LEN_MAX   = `DATA_LENGTH_MAX,
  parameter int ARB_MODE  = 0,
  localparam int LW = $clog2(LEN_MAX + 1),
  localparam int QW = $clog2(NUM_QUEUE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready_in,
  input  logic [NUM_QUEUE-1:0]    q_valid,
  input  logic [NUM_QUEUE*LW-1:0] q_length,
  output logic [NUM_QUEUE-1:0]    q_ready,
  output logic                    load,
  output logic [QW-1:0]           cur_qid,
  output logic                    fifo_rd_en,
  output logic                    out_sel,
  output logic                    rd_sop,
  output logic                    rd_vld,
  output logic                    rd_eop,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, GRANT, HDR, DATA} state_t;

  localparam logic [QW-1:0] LAST_Q = QW'(NUM_QUEUE - 1);
  localparam logic [QW:0]   NQ_W   = (QW + 1)'(NUM_QUEUE);

  state_t        state_q, state_d;
  logic [QW-1:0] cur_qid_q, cur_qid_d;
  logic [QW-1:0] rr_ptr_q, rr_ptr_d;
  logic [LW-1:0] cur_len_q, cur_len_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;
  logic [LW-1:0] len_arr [NUM_QUEUE];
  logic [QW-1:0] winner;
  logic [QW:0]   idx;
  logic          found;
  logic          any_valid;
  logic          pkt_done;

  always_comb begin
    for (int i = 0; i < NUM_QUEUE; i++) begin
      len_arr[i] = q_length[i*LW +: LW];
    end
  end

  assign any_valid = |q_valid;

  // Winner search starts at 0 (strict) or at rr_ptr with wrap (round-robin).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_QUEUE; i++) begin
      if (ARB_MODE == 0) begin
        idx = (QW + 1)'(i);
      end else begin
        idx = {1'b0, rr_ptr_q} + (QW + 1)'(i);
        if (idx >= NQ_W) begin
          idx = idx - NQ_W;
        end
      end
      if (!found && q_valid[idx[QW-1:0]]) begin
        winner = idx[QW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_qid_d  = cur_qid_q;
    cur_len_d  = cur_len_q;
    len_cnt_d  = len_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    q_ready    = '0;
    load       = 1'b0;
    fifo_rd_en = 1'b0;
    out_sel    = 1'b0;
    rd_sop     = 1'b0;
    rd_vld     = 1'b0;
    rd_eop     = 1'b0;
    pkt_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_in && any_valid) begin
          state_d   = GRANT;
          cur_qid_d = winner;
        end
      end
      GRANT: begin
        // A queue that withdrew its descriptor is not popped; fall back to IDLE.
        if (q_valid[cur_qid_q]) begin
          q_ready[cur_qid_q] = 1'b1;
          load               = 1'b1;
          cur_len_d          = len_arr[cur_qid_q];
          len_cnt_d          = '0;
          rr_ptr_d           = (cur_qid_q == LAST_Q) ? '0 : cur_qid_q + 1'b1;
          state_d            = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (ready_in) begin
          rd_vld  = 1'b1;
          rd_sop  = 1'b1;
          out_sel = 1'b1;
          if (cur_len_q == '0) begin
            rd_eop   = 1'b1;
            pkt_done = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (ready_in) begin
          rd_vld     = 1'b1;
          fifo_rd_en = 1'b1;
          len_cnt_d  = len_cnt_q + 1'b1;
          if (len_cnt_q == cur_len_q - 1'b1) begin
            rd_eop   = 1'b1;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The EOP beat chains straight into the next grant when work is waiting.
    if (pkt_done) begin
      if (any_valid) begin
        state_d   = GRANT;
        cur_qid_d = winner;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_qid_q <= '0;
      rr_ptr_q  <= '0;
      cur_len_q <= '0;
      len_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_qid_q <= cur_qid_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_len_q <= cur_len_d;
      len_cnt_q <= len_cnt_d;
    end
  end

  assign cur_qid = cur_qid_q;
  assign busy    = (state_q != IDLE);

endmodule
